// File: rtl/modificacion_ciclo_multicanal_pkg.sv
// Shared types and saturating arithmetic for the multichannel PWM duty controller.
// The optional MCT_AUTOREPEAT_EN macro does not change this file.
package mct_pkg;

    typedef enum logic [1:0] {
        EDIT_NONE = 2'd0,
        EDIT_UP   = 2'd1,
        EDIT_DOWN = 2'd2
    } edit_e;

    // Adds one bit of headroom so an overflow past the width's maximum can be clamped.
    function automatic logic [31:0] sat_add(input logic [31:0] val, input logic [31:0] step,
                                            input int unsigned width);
        logic [32:0] sum;
        logic [32:0] max_v;
        sum   = {1'b0, val} + {1'b0, step};
        max_v = (33'd1 << width) - 33'd1;
        if (sum > max_v) begin
            return max_v[31:0];
        end else begin
            return sum[31:0];
        end
    endfunction

    function automatic logic [31:0] sat_sub(input logic [31:0] val, input logic [31:0] step);
        logic signed [32:0] diff;
        diff = $signed({1'b0, val}) - $signed({1'b0, step});
        if (diff < 33'sd0) begin
            return 32'd0;
        end else begin
            return diff[31:0];
        end
    endfunction

endpackage

// File: rtl/modificacion_ciclo_multicanal_pulsador.sv
// Button edge detector emitting one-clock step pulses; with MCT_AUTOREPEAT_EN it
// also holds a repeat counter that adds steps while the button stays pressed.
module mct_pulsador
`ifdef MCT_AUTOREPEAT_EN
#(
    parameter int REPEAT_DELAY = 50_000_000,
    parameter int REPEAT_RATE  = 10_000_000
)
`endif
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    input  logic edit_en_i,
`ifdef MCT_AUTOREPEAT_EN
    input  logic hold_en_i,
`endif
    output logic step_o
);

    logic btn_q;
    logic armed_q;
    logic rise_s;

    // armed_q blocks a button held through reset from looking like a fresh press.
    assign rise_s = btn_i & ~btn_q & armed_q;

    // Edge-detector history and re-arm tracking.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            btn_q   <= 1'b0;
            armed_q <= ~btn_i;
        end else begin
            btn_q   <= btn_i;
            armed_q <= armed_q | ~btn_i;
        end
    end

`ifdef MCT_AUTOREPEAT_EN
    logic [31:0] hold_q;
    logic        rep_q;
    logic        fire_s;

    assign fire_s = hold_en_i && btn_i && (hold_q != 32'd0) &&
                    (rep_q ? (hold_q == 32'(REPEAT_RATE)) : (hold_q == 32'(REPEAT_DELAY)));

    // Hold counter: hold_q equals clocks since the press (or since the last repeat).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold_q <= 32'd0;
            rep_q  <= 1'b0;
        end else if (rise_s && hold_en_i) begin
            hold_q <= 32'd1;
            rep_q  <= 1'b0;
        end else if (hold_en_i && btn_i && (hold_q != 32'd0)) begin
            if (fire_s) begin
                hold_q <= 32'd1;
                rep_q  <= 1'b1;
            end else begin
                hold_q <= hold_q + 32'd1;
                rep_q  <= rep_q;
            end
        end else begin
            hold_q <= 32'd0;
            rep_q  <= 1'b0;
        end
    end

    assign step_o = edit_en_i & (rise_s | fire_s);
`else
    assign step_o = edit_en_i & rise_s;
`endif

endmodule

// File: rtl/modificacion_ciclo_multicanal.sv
// N-channel PWM duty controller with shadowed duty registers loaded at period wrap.
// Define MCT_AUTOREPEAT_EN to enable auto-repeat of held up/down buttons.
module modificacion_ciclo_multicanal
    import mct_pkg::*;
#(
    parameter int N            = 4,
    parameter int W            = 4,
    parameter int DIV          = 1,
    parameter int INIT_DUTY    = 2 ** (W - 1),
    parameter int STEP         = 1,
    parameter int REPEAT_DELAY = 50_000_000,
    parameter int REPEAT_RATE  = 10_000_000,
    localparam int SW          = (N > 1) ? $clog2(N) : 1
)(
    input  logic          clk_100MHz,
    input  logic          rst,
    input  logic          up,
    input  logic          down,
    input  logic          chip_select,
    input  logic [SW-1:0] sel,
    output logic [N-1:0]  signal_out,
    output logic [W-1:0]  ciclo_actual,
    output logic          period_start
);

    localparam int PERIOD = (2 ** W) - 1;
    localparam int PW     = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PW-1:0] pre_q;
    logic [W-1:0]  cnt_q;
    logic [W-1:0]  target_q [N];
    logic [W-1:0]  target_d [N];
    logic [W-1:0]  active_q [N];
    logic [N-1:0]  signal_out_q;
    logic          period_start_q;
    logic          tick_s;
    logic          wrap_s;
    logic          sel_ok_s;
    logic          edit_en_s;
    logic          step_up_s;
    logic          step_down_s;
    edit_e         edit_s;

    assign tick_s    = (pre_q == PW'(DIV - 1));
    assign wrap_s    = tick_s && (cnt_q == W'(PERIOD - 1));
    assign sel_ok_s  = (32'(sel) < 32'(N));
    assign edit_en_s = chip_select & sel_ok_s;

`ifdef MCT_AUTOREPEAT_EN
    mct_pulsador #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_pulsador_up (
        .clk_i(clk_100MHz), .rst_i(rst), .btn_i(up), .edit_en_i(edit_en_s),
        .hold_en_i(edit_en_s & ~down), .step_o(step_up_s));
    mct_pulsador #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_pulsador_down (
        .clk_i(clk_100MHz), .rst_i(rst), .btn_i(down), .edit_en_i(edit_en_s),
        .hold_en_i(edit_en_s & ~up), .step_o(step_down_s));
`else
    mct_pulsador u_pulsador_up (
        .clk_i(clk_100MHz), .rst_i(rst), .btn_i(up), .edit_en_i(edit_en_s), .step_o(step_up_s));
    mct_pulsador u_pulsador_down (
        .clk_i(clk_100MHz), .rst_i(rst), .btn_i(down), .edit_en_i(edit_en_s), .step_o(step_down_s));
`endif

    // Opposing steps in the same cycle cancel out.
    always_comb begin
        if (step_up_s && !step_down_s) begin
            edit_s = EDIT_UP;
        end else if (step_down_s && !step_up_s) begin
            edit_s = EDIT_DOWN;
        end else begin
            edit_s = EDIT_NONE;
        end
    end

    // Next target duty for the selected channel.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            target_d[i] = target_q[i];
            if (edit_en_s && (sel == SW'(i))) begin
                case (edit_s)
                    EDIT_UP:   target_d[i] = W'(sat_add(32'(target_q[i]), 32'(STEP), W));
                    EDIT_DOWN: target_d[i] = W'(sat_sub(32'(target_q[i]), 32'(STEP)));
                    default:   target_d[i] = target_q[i];
                endcase
            end else begin
                target_d[i] = target_q[i];
            end
        end
    end

    assign ciclo_actual = sel_ok_s ? target_q[sel] : '0;

    // Prescaler, period counter, shadow load and registered PWM outputs.
    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            pre_q          <= '0;
            cnt_q          <= '0;
            signal_out_q   <= '0;
            period_start_q <= 1'b0;
            for (int i = 0; i < N; i++) begin
                target_q[i] <= W'(INIT_DUTY);
                active_q[i] <= W'(INIT_DUTY);
            end
        end else begin
            pre_q          <= tick_s ? '0 : pre_q + PW'(1);
            period_start_q <= wrap_s;
            if (tick_s) begin
                cnt_q <= wrap_s ? '0 : cnt_q + W'(1);
            end
            for (int i = 0; i < N; i++) begin
                target_q[i]     <= target_d[i];
                signal_out_q[i] <= (cnt_q < active_q[i]);
                if (wrap_s) begin
                    active_q[i] <= target_q[i];
                end
            end
        end
    end

    assign signal_out   = signal_out_q;
    assign period_start = period_start_q;

endmodule

// File: tb/tb_modificacion_ciclo_multicanal.sv
// Scoreboard bench for modificacion_ciclo_multicanal (N=3, W=4, DIV=1, INIT_DUTY=8).
// Expected auto-repeat results follow MCT_AUTOREPEAT_EN when it is defined.
module tb_modificacion_ciclo_multicanal;

    logic       clk_100MHz = 1'b0;
    logic       rst = 1'b1;
    logic       up = 1'b0;
    logic       down = 1'b0;
    logic       chip_select = 1'b0;
    logic [1:0] sel = 2'd0;
    logic [2:0] signal_out;
    logic [3:0] ciclo_actual;
    logic       period_start;

    int n_checks = 0;
    int n_errors = 0;
    string       tag_q [$];
    logic [31:0] exp_q [$];

`ifdef MCT_AUTOREPEAT_EN
    localparam int EXP_HOLD = 13;
    localparam int EXP_MID  = 10;
`else
    localparam int EXP_HOLD = 9;
    localparam int EXP_MID  = 9;
`endif

    modificacion_ciclo_multicanal #(
        .N(3), .W(4), .DIV(1), .INIT_DUTY(8), .STEP(1), .REPEAT_DELAY(20), .REPEAT_RATE(5)
    ) dut (
        .clk_100MHz(clk_100MHz), .rst(rst), .up(up), .down(down), .chip_select(chip_select),
        .sel(sel), .signal_out(signal_out), .ciclo_actual(ciclo_actual), .period_start(period_start)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input int val);
        tag_q.push_back(tag);
        exp_q.push_back(32'(val));
    endtask

    task automatic sb_pop(input logic [31:0] obs);
        if (exp_q.size() == 0) begin
            check_value("sb_underflow", 32'd0, 32'd1);
        end else begin
            check_value(tag_q.pop_front(), obs, exp_q.pop_front());
        end
    endtask

    task automatic step_clk();
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic pulse_up();
        up = 1'b1; step_clk(); up = 1'b0; step_clk();
    endtask

    task automatic pulse_down();
        down = 1'b1; step_clk(); down = 1'b0; step_clk();
    endtask

    task automatic expect_duty(input string tag, input int val);
        sb_push(tag, val);
        sb_pop(32'(ciclo_actual));
    endtask

    task automatic wait_period_start();
        int n = 0;
        while (period_start !== 1'b1 && n < 40) begin
            step_clk();
            n++;
        end
        if (period_start !== 1'b1) check_value("period_start_timeout", 32'd0, 32'd1);
    endtask

    // One full period: per-channel high counts, one wrap pulse on its last clock.
    task automatic measure_period(input string tag, input int edit_at,
                                  input int e0, input int e1, input int e2);
        int hi [3];
        int ps_cnt = 0;
        for (int c = 0; c < 3; c++) hi[c] = 0;
        sb_push({tag, "_ch0"}, e0);
        sb_push({tag, "_ch1"}, e1);
        sb_push({tag, "_ch2"}, e2);
        sb_push({tag, "_ps_count"}, 1);
        sb_push({tag, "_ps_last"}, 1);
        wait_period_start();
        for (int i = 0; i < 15; i++) begin
            up = (i == edit_at);
            step_clk();
            for (int c = 0; c < 3; c++) hi[c] += int'(signal_out[c]);
            ps_cnt += int'(period_start);
        end
        up = 1'b0;
        for (int c = 0; c < 3; c++) sb_pop(32'(hi[c]));
        sb_pop(32'(ps_cnt));
        sb_pop(32'(period_start));
    endtask

    initial begin
        // Reset held for two clocks.
        step_clk(); step_clk();
        sb_push("rst_duty", 8);
        sb_push("rst_signal_out", 0);
        sb_push("rst_period_start", 0);
        sb_pop(32'(ciclo_actual));
        sb_pop(32'(signal_out));
        sb_pop(32'(period_start));
        rst = 1'b0;
        measure_period("rst_pwm", -1, 8, 8, 8);

        // Saturation on channel 1.
        chip_select = 1'b1; sel = 2'd1;
        for (int k = 0; k < 10; k++) pulse_up();
        expect_duty("sat_high", 15);
        measure_period("sat_high_pwm", -1, 8, 15, 8);
        for (int k = 0; k < 20; k++) pulse_down();
        expect_duty("sat_low", 0);
        measure_period("sat_low_pwm", -1, 8, 0, 8);

        // Simultaneous rise on channel 2 cancels.
        sel = 2'd2;
        up = 1'b1; down = 1'b1; step_clk();
        up = 1'b0; down = 1'b0; step_clk();
        expect_duty("simul", 8);
        pulse_down();
        expect_duty("down_after_simul", 7);

        // Shadow load on channel 0: mid-period edit, then an edit on the wrap edge.
        sel = 2'd0;
        measure_period("shadow_cur", 5, 8, 0, 7);
        measure_period("shadow_next", -1, 9, 0, 7);
        measure_period("wrap_edit_cur", 14, 9, 0, 7);
        measure_period("wrap_edit_next", -1, 9, 0, 7);
        measure_period("wrap_edit_later", -1, 10, 0, 7);
        expect_duty("wrap_edit_duty", 10);

        // Gating.
        chip_select = 1'b0;
        for (int k = 0; k < 3; k++) pulse_up();
        expect_duty("cs_off", 10);
        chip_select = 1'b1; sel = 2'd3;
        pulse_up(); pulse_up(); pulse_down();
        expect_duty("sel_oob", 0);
        sel = 2'd0; #1; expect_duty("sel_oob_ch0", 10);
        sel = 2'd1; #1; expect_duty("sel_oob_ch1", 0);
        sel = 2'd2; #1; expect_duty("sel_oob_ch2", 7);
        sel = 2'd0; chip_select = 1'b0; up = 1'b1;
        step_clk(); step_clk();
        chip_select = 1'b1;
        step_clk(); step_clk(); step_clk();
        expect_duty("cs_raise_held", 10);
        up = 1'b0; step_clk();

        // Hold behaviour and reset during a hold.
        rst = 1'b1; step_clk(); rst = 1'b0;
        expect_duty("hold_start", 8);
        up = 1'b1;
        for (int k = 0; k < 40; k++) step_clk();
        up = 1'b0; step_clk();
        expect_duty("hold_40", EXP_HOLD);
        rst = 1'b1; step_clk(); rst = 1'b0;
        up = 1'b1;
        for (int k = 0; k < 25; k++) step_clk();
        expect_duty("hold_25", EXP_MID);
        rst = 1'b1; step_clk(); rst = 1'b0;
        expect_duty("rst_mid_hold", 8);
        for (int k = 0; k < 40; k++) step_clk();
        up = 1'b0; step_clk();
        expect_duty("held_after_rst", 8);
        pulse_up();
        expect_duty("rearmed_after_rst", 9);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
